// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump controller's control, regfile read port and output stream.
// master is the dump engine; slave is whoever drives start/ready and serves rd_data.
`timescale 1ns/1ps
interface regfile_dump_reader_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        input  start, abort, first_addr, last_addr, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        output start, abort, first_addr, last_addr, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks a wrap-around register range through one combinational
// read port and streams each captured value out with its address.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | rd_addr holds first address; capture it on the next edge
// HOLD  | word presented on out_*; each handshake captures the next word
// DONE  | one-cycle done pulse after the last word was accepted
`timescale 1ns/1ps
module regfile_dump_reader #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    regfile_dump_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] rd_addr_inc;
    logic [AW-1:0] last_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic          load;
    logic          capture;

    always_comb begin
        rd_addr_inc = (rd_addr_q == AW'(NREGS - 1)) ? '0 : rd_addr_q + AW'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    load    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    // Accepting a non-final word refills the output on the same edge.
                    if (out_last_q) state_d = DONE;
                    else            capture = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_addr_q  <= '0;
            last_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (load) begin
                rd_addr_q <= bus.first_addr;
                last_q    <= bus.last_addr;
            end
            if (capture) begin
                out_data_q <= bus.rd_data;
                out_addr_q <= rd_addr_q;
                out_last_q <= (rd_addr_q == last_q);
                rd_addr_q  <= rd_addr_inc;
            end else if (state_d != HOLD) begin
                out_last_q <= 1'b0;
            end
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == FETCH) || (state_q == HOLD);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a queue-based dump model checked every cycle,
// directed scenarios with literal expectations, then randomized dumps.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic Clk;
    logic Rst_n;

    regfile_dump_reader_if #(.AW(AW), .DW(DW)) bus ();

    regfile_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [NREGS];
    assign bus.rd_data = mem[bus.rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model: 0 idle, 1 waiting for first capture, 2 presenting q[0], 3 done pulse.
    // q holds the addresses still owed to the consumer; m_data is the value of q[0]
    // as it stood in the register file at its capture edge.
    int            m_mode = 0;
    int            m_q[$];
    logic [DW-1:0] m_data = '0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            case (m_mode)
                0: if (bus.start && !bus.abort) begin
                    int n;
                    n = ((int'(bus.last_addr) - int'(bus.first_addr) + NREGS) % NREGS) + 1;
                    m_q.delete();
                    for (int i = 0; i < n; i++) m_q.push_back((int'(bus.first_addr) + i) % NREGS);
                    m_mode = 1;
                end
                1: if (bus.abort) begin
                    m_q.delete();
                    m_mode = 0;
                end else begin
                    m_data = mem[m_q[0]];
                    m_mode = 2;
                end
                2: if (bus.abort) begin
                    m_q.delete();
                    m_mode = 0;
                end else if (bus.out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_mode = 3;
                    else                 m_data = mem[m_q[0]];
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("rst_valid", bus.out_valid, 0);
            check("rst_busy",  bus.busy, 0);
            check("rst_done",  bus.done, 0);
            check("rst_last",  bus.out_last, 0);
            check("rst_rdaddr", bus.rd_addr, 0);
            check("rst_odata", bus.out_data, 0);
            check("rst_oaddr", bus.out_addr, 0);
        end else begin
            check("out_valid", bus.out_valid, m_mode == 2);
            check("busy", bus.busy, (m_mode == 1) || (m_mode == 2));
            check("done", bus.done, m_mode == 3);
            if (m_mode == 2) begin
                check("out_addr", bus.out_addr, m_q[0]);
                check("out_data", bus.out_data, m_data);
                check("out_last", bus.out_last, m_q.size() == 1);
                check("rd_addr_hold", bus.rd_addr, (m_q[0] + 1) % NREGS);
            end else begin
                check("out_last_idle", bus.out_last, 0);
                if (m_mode == 1) check("rd_addr_fetch", bus.rd_addr, m_q[0]);
            end
        end
    end

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        bit            last;
    } beat_t;

    beat_t beats[$];
    int    done_cnt = 0;

    always @(posedge Clk) begin
        if (Rst_n && bus.out_valid && bus.out_ready && !bus.abort)
            beats.push_back('{addr: int'(bus.out_addr), data: bus.out_data, last: bus.out_last});
        if (Rst_n && bus.done) done_cnt++;
    end

    task automatic start_dump(int f, int l);
        @(negedge Clk);
        bus.first_addr = AW'(f);
        bus.last_addr  = AW'(l);
        bus.start      = 1'b1;
        @(negedge Clk);
        bus.start      = 1'b0;
    endtask

    // ready_mode: 1 always ready, 2 alternating, 3 random
    task automatic run(int ready_mode, int budget, string name);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (ready_mode)
                1:       bus.out_ready = 1'b1;
                2:       bus.out_ready = (i % 2 == 1);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge Clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        bus.out_ready  = 1'b0;
        for (int k = 0; k < NREGS; k++) mem[k] = 32'(k) * 32'h1111_1111;
        Rst_n = 1'b1;
        #1 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("reset_valid", bus.out_valid, 0);
        check("reset_rd_addr", bus.rd_addr, 0);

        // basic 3-word dump, always ready
        beats.delete(); done_cnt = 0;
        bus.out_ready = 1'b1;
        start_dump(3, 5);
        run(1, 20, "t1_done_seen");
        check("t1_count", beats.size(), 3);
        if (beats.size() == 3) begin
            check("t1_a0", beats[0].addr, 3); check("t1_d0", beats[0].data, 32'h3333_3333);
            check("t1_a1", beats[1].addr, 4); check("t1_d1", beats[1].data, 32'h4444_4444);
            check("t1_a2", beats[2].addr, 5); check("t1_d2", beats[2].data, 32'h5555_5555);
            check("t1_last", {beats[0].last, beats[1].last, beats[2].last}, 3'b001);
        end
        check("t1_done_cnt", done_cnt, 1);

        // wrapping range with toggling ready
        beats.delete(); done_cnt = 0;
        start_dump(30, 1);
        run(2, 40, "t2_done_seen");
        check("t2_count", beats.size(), 4);
        if (beats.size() == 4) begin
            check("t2_a0", beats[0].addr, 30); check("t2_a1", beats[1].addr, 31);
            check("t2_a2", beats[2].addr, 0);  check("t2_a3", beats[3].addr, 1);
            check("t2_d2", beats[2].data, 0);  check("t2_d3", beats[3].data, 32'h1111_1111);
        end

        // single word, latency
        beats.delete(); done_cnt = 0;
        bus.out_ready = 1'b0;
        start_dump(7, 7);
        check("t3_valid_after_1", bus.out_valid, 0);
        @(negedge Clk);
        check("t3_valid_after_2", bus.out_valid, 1);
        check("t3_addr", bus.out_addr, 7);
        check("t3_last", bus.out_last, 1);
        run(1, 10, "t3_done_seen");
        check("t3_count", beats.size(), 1);

        // snapshot: held word unaffected by a later write
        beats.delete(); done_cnt = 0;
        bus.out_ready = 1'b0;
        start_dump(4, 5);
        @(negedge Clk);
        mem[4] = 32'hDEAD_BEEF;
        repeat (3) @(negedge Clk);
        check("t4_held_addr", bus.out_addr, 4);
        check("t4_held_data", bus.out_data, 32'h4444_4444);
        run(1, 10, "t4_done_seen");
        beats.delete();
        start_dump(4, 4);
        run(1, 10, "t4b_done_seen");
        if (beats.size() == 1) check("t4_new_data", beats[0].data, 32'hDEAD_BEEF);
        else check("t4b_count", beats.size(), 1);

        // abort mid-dump
        beats.delete(); done_cnt = 0;
        bus.out_ready = 1'b1;
        start_dump(0, 9);
        repeat (3) @(negedge Clk);
        bus.out_ready = 1'b0;
        @(negedge Clk);
        bus.abort = 1'b1;
        @(negedge Clk);
        bus.abort = 1'b0;
        check("t5_valid", bus.out_valid, 0);
        check("t5_busy", bus.busy, 0);
        repeat (5) @(negedge Clk);
        check("t5_no_done", done_cnt, 0);
        beats.delete();
        start_dump(2, 3);
        run(1, 10, "t5_restart_done");
        if (beats.size() == 2) begin
            check("t5_a0", beats[0].addr, 2); check("t5_a1", beats[1].addr, 3);
        end else check("t5_count", beats.size(), 2);

        // asynchronous reset mid-dump
        bus.out_ready = 1'b1;
        start_dump(10, 20);
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("t6_valid", bus.out_valid, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_odata", bus.out_data, 0);
        check("t6_oaddr", bus.out_addr, 0);
        check("t6_rdaddr", bus.rd_addr, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        beats.delete();
        start_dump(15, 16);
        run(1, 10, "t6_restart_done");
        if (beats.size() == 2) begin
            check("t6_a0", beats[0].addr, 15); check("t6_a1", beats[1].addr, 16);
        end else check("t6_count", beats.size(), 2);

        // randomized dumps with stray starts, aborts and regfile writes
        for (int it = 0; it < 40; it++) begin
            bit idle_seen;
            start_dump($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
            for (int c = 0; c < 150; c++) begin
                bus.out_ready  = 1'($urandom_range(0, 1));
                bus.abort      = ($urandom_range(0, 59) == 0);
                bus.start      = ($urandom_range(0, 7) == 0);
                bus.first_addr = AW'($urandom_range(0, NREGS - 1));
                bus.last_addr  = AW'($urandom_range(0, NREGS - 1));
                if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, NREGS - 1)] = $urandom;
                @(negedge Clk);
                if (!bus.busy && !bus.done) break;
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
            bus.out_ready = 1'b1;
            idle_seen = 1'b0;
            for (int c = 0; c < 80; c++) begin
                if (!bus.busy && !bus.done) begin
                    idle_seen = 1'b1;
                    break;
                end
                @(negedge Clk);
            end
            check("rand_drain", idle_seen, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
